// File: rtl/tuner_pkg.sv
// rtl/tuner_pkg.sv - shared sequencer states, RAM owner codes and default widths
package tuner_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_FFT     = 3'd2,
    S_PEAK    = 3'd3,
    S_PUBLISH = 3'd4,
    S_GAP     = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CAP  = 2'd1,
    OWN_FFT  = 2'd2,
    OWN_PK   = 2'd3
  } mem_owner_t;

  // Exactly one engine may touch the RAM, tied to the phase it runs in.
  function automatic mem_owner_t owner_of(seq_state_t s);
    case (s)
      S_CAPTURE: return OWN_CAP;
      S_FFT:     return OWN_FFT;
      S_PEAK:    return OWN_PK;
      default:   return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sample_mem_mux.sv
// rtl/sample_mem_mux.sv - owner-selected combinational mux for the sample RAM port
module sample_mem_mux
  import tuner_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  mem_owner_t        owner,
  input  logic              cap_we,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_wdata,
  input  logic              fft_we,
  input  logic [ADDR_W-1:0] fft_addr,
  input  logic [DATA_W-1:0] fft_wdata,
  input  logic [ADDR_W-1:0] pk_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (owner)
      OWN_CAP: begin
        mem_we    = cap_we;
        mem_addr  = cap_addr;
        mem_wdata = cap_wdata;
      end
      OWN_FFT: begin
        mem_we    = fft_we;
        mem_addr  = fft_addr;
        mem_wdata = fft_wdata;
      end
      OWN_PK:  mem_addr = pk_addr;
      default: ;
    endcase
  end

endmodule

// File: rtl/tuner_sequencer.sv
// rtl/tuner_sequencer.sv - frame sequencer: capture, FFT, peak search, publish
module tuner_sequencer
  import tuner_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int BIN_W          = 10,
  parameter int GAP_CYCLES     = 1024000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              single_shot,
  input  logic              clear_err,
  output logic              cap_start,
  input  logic              cap_done,
  input  logic              cap_we,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_wdata,
  output logic              fft_start,
  input  logic              fft_done,
  input  logic              fft_we,
  input  logic [ADDR_W-1:0] fft_addr,
  input  logic [DATA_W-1:0] fft_wdata,
  output logic              pk_start,
  input  logic              pk_done,
  input  logic [ADDR_W-1:0] pk_addr,
  input  logic [BIN_W-1:0]  pk_bin,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BIN_W-1:0]  result_bin,
  output logic              result_valid,
  output logic              busy,
  output logic              error,
  output logic [2:0]        phase
);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  seq_state_t        state_q, state_d;
  mem_owner_t        owner_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              error_q, error_d;
  logic [BIN_W-1:0]  bin_q, bin_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
      error_q <= 1'b0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_of(state_d);
      cnt_q   <= cnt_d;
      error_q <= error_d;
      bin_q   <= bin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    error_d = error_q;
    bin_d   = bin_q;
    case (state_q)
      S_IDLE: begin
        if (clear_err) begin
          error_d = 1'b0;
        end else if (!error_q && (run || single_shot)) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end
      end
      S_CAPTURE, S_FFT, S_PEAK: begin
        // Only the active engine's done counts; stray pulses are dropped here.
        if ((state_q == S_CAPTURE && cap_done) ||
            (state_q == S_FFT && fft_done) ||
            (state_q == S_PEAK && pk_done)) begin
          cnt_d = '0;
          case (state_q)
            S_CAPTURE: state_d = S_FFT;
            S_FFT:     state_d = S_PEAK;
            default: begin
              state_d = S_PUBLISH;
              bin_d   = pk_bin;
            end
          endcase
        end else if (cnt_q == TO_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PUBLISH: begin
        state_d = run ? S_GAP : S_IDLE;
        cnt_d   = '0;
      end
      S_GAP: begin
        if (!run) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign cap_start    = (state_q == S_CAPTURE);
  assign fft_start    = (state_q == S_FFT);
  assign pk_start     = (state_q == S_PEAK);
  assign result_valid = (state_q == S_PUBLISH);
  assign result_bin   = bin_q;
  assign busy         = (state_q != S_IDLE);
  assign error        = error_q;
  assign phase        = state_q;

  sample_mem_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mux (
    .owner    (owner_q),
    .cap_we   (cap_we),
    .cap_addr (cap_addr),
    .cap_wdata(cap_wdata),
    .fft_we   (fft_we),
    .fft_addr (fft_addr),
    .fft_wdata(fft_wdata),
    .pk_addr  (pk_addr),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata)
  );

endmodule
